// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - shared types and defaults for the result bank
package result_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_t;

endpackage

// File: rtl/result_clear_seq.sv
// rtl/result_clear_seq.sv - clear sequencer walking every bank entry once
//
// Purpose: on clear_start (ignored while already clearing) step clear_idx
// from 0 to DEPTH-1, one entry per cycle, then return to idle.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   clear_start  request a clear sequence
//   clear_busy   high while an entry is being cleared (exactly DEPTH cycles)
//   clear_idx    entry cleared at the next rising edge while clear_busy
module result_clear_seq
  import result_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_start,
  output logic             clear_busy,
  output logic [SEL_W-1:0] clear_idx
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  clear_state_t     state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (clear_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_idx  = idx_q;

endmodule

// File: rtl/result_bank.sv
// rtl/result_bank.sv - multi-entry result store with dual read ports and sequenced clear
//
// Purpose: DEPTH entries of DATA_W data plus a valid bit. One write port,
// two combinational read ports with write-first bypass, a running count of
// valid entries and a one-entry-per-cycle clear sequence.
// Optional feature: define RESULT_BANK_ACCUM_EN to make writes with accum=1
// add in_data to the stored value (0 if the entry is invalid).
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   w_enable/in_sel/in_data write request, index and data
//   accum                   accumulate-write select (only with RESULT_BANK_ACCUM_EN)
//   clear_start             start the clear sequence
//   rd_sel_a/b              read indices; rd_data_a/b, rd_valid_a/b read results
//   clear_busy              clear sequence running
//   valid_count, all_valid  number of valid entries, all entries valid
//   wr_err                  one-cycle pulse per rejected write
module result_bank
  import result_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int SEL_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              w_enable,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              accum,
  input  logic              clear_start,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_a,
  output logic              rd_valid_b,
  output logic              clear_busy,
  output logic [SEL_W:0]    valid_count,
  output logic              all_valid,
  output logic              wr_err
);

  localparam logic [SEL_W:0] DEPTH_V = (SEL_W + 1)'(DEPTH);
  localparam logic [SEL_W:0] CNT_ONE = (SEL_W + 1)'(1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [SEL_W:0]    cnt_q;
  logic              err_q;
  logic [SEL_W-1:0]  clear_idx;
  logic              in_range;
  logic              wr_accept;
  logic [DATA_W-1:0] wr_value;

  result_clear_seq #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_clear_seq (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_idx   (clear_idx)
  );

  // clear_start beats a same-cycle write, so it rejects the write too.
  assign in_range  = ({1'b0, in_sel} < DEPTH_V);
  assign wr_accept = w_enable & in_range & ~clear_busy & ~clear_start;

`ifdef RESULT_BANK_ACCUM_EN
  always_comb begin
    wr_value = in_data;
    if (accum) wr_value = in_data + (valid_q[in_sel] ? data_q[in_sel] : '0);
  end
`else
  logic unused_accum;
  assign wr_value     = in_data;
  assign unused_accum = accum;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear_busy && clear_idx == SEL_W'(i)) begin
          data_q[i]  <= '0;
          valid_q[i] <= 1'b0;
        end else if (wr_accept && in_sel == SEL_W'(i)) begin
          data_q[i]  <= wr_value;
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  // Writes are never accepted while clearing, so increment and decrement
  // can not coincide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_accept && !valid_q[in_sel]) cnt_q <= cnt_q + CNT_ONE;
      else if (clear_busy && valid_q[clear_idx]) cnt_q <= cnt_q - CNT_ONE;
      err_q <= w_enable & ~wr_accept;
    end
  end

  function automatic logic [DATA_W:0] read_port(input logic [SEL_W-1:0] sel);
    if ({1'b0, sel} >= DEPTH_V) return '0;
    if (wr_accept && sel == in_sel) return {1'b1, wr_value};
    return {valid_q[sel], data_q[sel]};
  endfunction

  assign {rd_valid_a, rd_data_a} = read_port(rd_sel_a);
  assign {rd_valid_b, rd_data_b} = read_port(rd_sel_b);

  assign valid_count = cnt_q;
  assign all_valid   = (cnt_q == DEPTH_V);
  assign wr_err      = err_q;

endmodule

// File: tb/tb_result_bank.sv
// tb/tb_result_bank.sv - self-checking bench for result_bank
module tb_result_bank;

`ifdef RESULT_BANK_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif
  localparam logic [31:0] ACCV = ACC_EN ? 32'h1 : 32'h2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst;

  logic        w_enable, accum, clear_start;
  logic [3:0]  in_sel, rd_sel_a, rd_sel_b;
  logic [31:0] in_data, rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, clear_busy, all_valid, wr_err;
  logic [4:0]  valid_count;

  logic        w_t, accum_t, clear_t;
  logic [3:0]  sel_t, ra_t, rb_t;
  logic [31:0] data_t, da_t, db_t;
  logic        va_t, vb_t, busy_t, all_t, err_t;
  logic [4:0]  cnt_t;

  result_bank #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .n_rst(n_rst), .w_enable(w_enable), .in_sel(in_sel), .in_data(in_data),
    .accum(accum), .clear_start(clear_start), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid_a(rd_valid_a),
    .rd_valid_b(rd_valid_b), .clear_busy(clear_busy), .valid_count(valid_count),
    .all_valid(all_valid), .wr_err(wr_err)
  );

  result_bank #(.DATA_W(32), .DEPTH(10)) dut10 (
    .clk(clk), .n_rst(n_rst), .w_enable(w_t), .in_sel(sel_t), .in_data(data_t),
    .accum(accum_t), .clear_start(clear_t), .rd_sel_a(ra_t), .rd_sel_b(rb_t),
    .rd_data_a(da_t), .rd_data_b(db_t), .rd_valid_a(va_t), .rd_valid_b(vb_t),
    .clear_busy(busy_t), .valid_count(cnt_t), .all_valid(all_t), .wr_err(err_t)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: plain arrays plus "clear cursor" (-1 when idle).
  logic [31:0] m_data [16];
  bit          m_valid [16];
  int          m_pos;

  logic [31:0] s_da, s_db;
  logic        s_va, s_vb, s_busy, s_all, s_err;
  logic [4:0]  s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_data[i] = '0;
      m_valid[i] = 1'b0;
    end
    m_pos = -1;
  endtask

  // Called at posedge+1; applies one cycle of stimulus and checks it against the model.
  task automatic step(input bit we, input int sel, input logic [31:0] d, input bit acc,
                      input bit clr, input int ra, input int rb);
    bit          ok;
    logic [31:0] nv;
    logic [31:0] e_da, e_db;
    bit          e_va, e_vb, e_err;
    w_enable = we; in_sel = 4'(sel); in_data = d; accum = acc; clear_start = clr;
    rd_sel_a = 4'(ra); rd_sel_b = 4'(rb);
    ok = we && sel < 16 && m_pos < 0 && !clr;
    nv = (ACC_EN && acc) ? ((m_valid[sel] ? m_data[sel] : 32'h0) + d) : d;
    e_da = (ok && ra == sel) ? nv : m_data[ra];
    e_va = (ok && ra == sel) ? 1'b1 : m_valid[ra];
    e_db = (ok && rb == sel) ? nv : m_data[rb];
    e_vb = (ok && rb == sel) ? 1'b1 : m_valid[rb];
    @(negedge clk);
    s_da = rd_data_a; s_va = rd_valid_a; s_db = rd_data_b; s_vb = rd_valid_b;
    chk("model_rd_a_data", s_da, e_da);
    chk("model_rd_a_valid", 32'(s_va), 32'(e_va));
    chk("model_rd_b_data", s_db, e_db);
    chk("model_rd_b_valid", 32'(s_vb), 32'(e_vb));
    @(posedge clk);
    if (m_pos >= 0) begin
      m_data[m_pos] = '0;
      m_valid[m_pos] = 1'b0;
      m_pos = (m_pos == 15) ? -1 : m_pos + 1;
    end else if (clr) begin
      m_pos = 0;
    end
    if (ok) begin
      m_data[sel] = nv;
      m_valid[sel] = 1'b1;
    end
    e_err = we && !ok;
    #1;
    s_cnt = valid_count; s_all = all_valid; s_busy = clear_busy; s_err = wr_err;
    chk("model_valid_count", 32'(s_cnt), 32'(m_count()));
    chk("model_all_valid", 32'(s_all), 32'(m_count() == 16));
    chk("model_clear_busy", 32'(s_busy), 32'(m_pos >= 0));
    chk("model_wr_err", 32'(s_err), 32'(e_err));
  endtask

  typedef struct {
    int          we; int sel; logic [31:0] d; int acc; int clr; int ra; int rb;
    logic [31:0] da; int va; logic [31:0] db; int vb; int cnt; int err; int busy;
  } vec_t;
  vec_t tv [11];

  int busy_cycles;

  initial begin
    tv[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 3, 0, 32'hDEADBEEF, 1, 32'h0, 0, 1, 0, 0};
    tv[1]  = '{0, 0, 32'h0, 0, 0, 3, 5, 32'hDEADBEEF, 1, 32'h0, 0, 1, 0, 0};
    tv[2]  = '{1, 5, 32'h55, 0, 0, 3, 5, 32'hDEADBEEF, 1, 32'h55, 1, 2, 0, 0};
    tv[3]  = '{1, 5, 32'h66, 0, 0, 0, 5, 32'h0, 0, 32'h66, 1, 2, 0, 0};
    tv[4]  = '{1, 1, 32'hFFFFFFFF, 0, 0, 1, 5, 32'hFFFFFFFF, 1, 32'h66, 1, 3, 0, 0};
    tv[5]  = '{1, 1, 32'h2, 1, 0, 1, 3, ACCV, 1, 32'hDEADBEEF, 1, 3, 0, 0};
    tv[6]  = '{0, 0, 32'h0, 0, 0, 1, 3, ACCV, 1, 32'hDEADBEEF, 1, 3, 0, 0};
    tv[7]  = '{1, 7, 32'h9, 0, 1, 7, 1, 32'h0, 0, ACCV, 1, 3, 1, 1};
    tv[8]  = '{1, 2, 32'h4, 0, 0, 2, 0, 32'h0, 0, 32'h0, 0, 3, 1, 1};
    tv[9]  = '{0, 0, 32'h0, 0, 0, 1, 3, ACCV, 1, 32'hDEADBEEF, 1, 2, 0, 1};
    tv[10] = '{0, 0, 32'h0, 0, 0, 1, 3, 32'h0, 0, 32'hDEADBEEF, 1, 2, 0, 1};

    n_rst = 1'b0;
    w_enable = 0; in_sel = 0; in_data = 0; accum = 0; clear_start = 0; rd_sel_a = 0; rd_sel_b = 0;
    w_t = 0; sel_t = 0; data_t = 0; accum_t = 0; clear_t = 0; ra_t = 0; rb_t = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_count", 32'(valid_count), 32'h0);
    chk("reset_all_valid", 32'(all_valid), 32'h0);
    chk("reset_clear_busy", 32'(clear_busy), 32'h0);
    chk("reset_wr_err", 32'(wr_err), 32'h0);
    chk("reset_rd_a", {31'h0, rd_valid_a} | rd_data_a, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: writes, bypass, accumulate, clear priority, writes during clear.
    for (int i = 0; i < 11; i++) begin
      step(tv[i].we != 0, tv[i].sel, tv[i].d, tv[i].acc != 0, tv[i].clr != 0, tv[i].ra, tv[i].rb);
      chk($sformatf("tv%0d_rd_a_data", i), s_da, tv[i].da);
      chk($sformatf("tv%0d_rd_a_valid", i), 32'(s_va), 32'(tv[i].va));
      chk($sformatf("tv%0d_rd_b_data", i), s_db, tv[i].db);
      chk($sformatf("tv%0d_rd_b_valid", i), 32'(s_vb), 32'(tv[i].vb));
      chk($sformatf("tv%0d_valid_count", i), 32'(s_cnt), 32'(tv[i].cnt));
      chk($sformatf("tv%0d_wr_err", i), 32'(s_err), 32'(tv[i].err));
      chk($sformatf("tv%0d_clear_busy", i), 32'(s_busy), 32'(tv[i].busy));
    end
    for (int k = 0; k < 40 && m_pos >= 0; k++) step(0, 0, 0, 0, 0, k % 16, (k + 7) % 16);
    chk("drain_clear_busy", 32'(clear_busy), 32'h0);

    // Fill everything, then a full clear with a write attempted part-way.
    for (int i = 0; i < 16; i++) step(1, i, $urandom, 0, 0, i, $urandom_range(0, 15));
    chk("fill_all_valid", 32'(all_valid), 32'h1);
    chk("fill_valid_count", 32'(valid_count), 32'd16);
    step(0, 0, 0, 0, 1, 0, 1);
    busy_cycles = int'(s_busy);
    for (int k = 0; k < 40 && s_busy; k++) begin
      step(k == 3 || k == 9, 4, 32'h1234, 0, k == 5, k % 16, 4);
      if (s_busy) busy_cycles++;
    end
    chk("clear_busy_len", 32'(busy_cycles), 32'd16);
    chk("clear_end_count", 32'(valid_count), 32'h0);

    // Reset asserted while the clear is working on entry 7.
    for (int i = 0; i < 16; i++) step(1, i, $urandom | 32'h1, 0, 0, i, 15 - i);
    step(0, 0, 0, 0, 1, 8, 15);
    for (int k = 0; k < 20 && m_pos != 7; k++) step(0, 0, 0, 0, 0, 8, 15);
    chk("rst_mid_clear_index", 32'(m_pos), 32'd7);
    n_rst = 1'b0;
    rd_sel_a = 4'd8; rd_sel_b = 4'd15;
    #1;
    chk("rst_mid_valid_count", 32'(valid_count), 32'h0);
    chk("rst_mid_all_valid", 32'(all_valid), 32'h0);
    chk("rst_mid_clear_busy", 32'(clear_busy), 32'h0);
    chk("rst_mid_wr_err", 32'(wr_err), 32'h0);
    chk("rst_mid_rd_a", {31'h0, rd_valid_a} | rd_data_a, 32'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 8; i < 16; i++) begin
      step(0, 0, 0, 0, 0, i, i);
      chk("post_rst_entry_data", s_da, 32'h0);
      chk("post_rst_entry_valid", 32'(s_va), 32'h0);
    end
    // Fresh clear after reset must start again at entry 0.
    step(1, 0, 32'hAA, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("restart_entry0_cleared", 32'(s_va), 32'h0);
    for (int k = 0; k < 40 && m_pos >= 0; k++) step(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 15),
           ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
           $urandom_range(0, 1) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 15), $urandom_range(0, 15));

    // DEPTH=10 instance: out-of-range indices.
    w_t = 1; sel_t = 4'd12; data_t = 32'h1; ra_t = 4'd12; rb_t = 4'd9;
    @(negedge clk);
    chk("d10_rd12_data", da_t, 32'h0);
    chk("d10_rd12_valid", 32'(va_t), 32'h0);
    @(posedge clk); #1;
    chk("d10_sel12_wr_err", 32'(err_t), 32'h1);
    chk("d10_sel12_count", 32'(cnt_t), 32'h0);
    w_t = 0;
    @(posedge clk); #1;
    chk("d10_wr_err_pulse", 32'(err_t), 32'h0);
    w_t = 1; sel_t = 4'd9; data_t = 32'h99;
    @(negedge clk);
    chk("d10_bypass9_data", db_t, 32'h99);
    chk("d10_bypass9_valid", 32'(vb_t), 32'h1);
    @(posedge clk); #1;
    chk("d10_sel9_count", 32'(cnt_t), 32'h1);
    chk("d10_sel9_wr_err", 32'(err_t), 32'h0);
    sel_t = 4'd10; data_t = 32'h5; ra_t = 4'd10;
    @(negedge clk);
    chk("d10_rd10_valid", 32'(va_t), 32'h0);
    @(posedge clk); #1;
    chk("d10_sel10_wr_err", 32'(err_t), 32'h1);
    chk("d10_sel10_count", 32'(cnt_t), 32'h1);
    chk("d10_all_valid", 32'(all_t), 32'h0);
    w_t = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/result_bank.md
RESULT_BANK -- requirements
Module: result_bank

Interface
REQ-001 Parameter DATA_W, default 32, shall set the width of each result entry.
REQ-002 Parameter DEPTH, default 16, shall set the entry count (2..256, need not be a power of two).
REQ-003 Localparam SEL_W = $clog2(DEPTH) shall set all index widths.
REQ-004 clk  in  1  shall be the clock; all state updates on its rising edge.
REQ-005 n_rst  in  1  shall be the reset: asynchronous, active-low.
REQ-006 w_enable  in  1  shall request a write of in_data to entry in_sel.
REQ-007 in_sel  in  SEL_W  shall be the write index.
REQ-008 in_data  in  DATA_W  shall be the write data.
REQ-009 accum  in  1  shall select accumulate-write (see Configuration).
REQ-010 clear_start  in  1  shall request a sequenced clear of all entries.
REQ-011 rd_sel_a, rd_sel_b  in  SEL_W  shall be the two independent read indices.
REQ-012 rd_data_a, rd_data_b  out  DATA_W  shall be the read data.
REQ-013 rd_valid_a, rd_valid_b  out  1  shall be the valid flag of the selected entry.
REQ-014 clear_busy  out  1  shall be high while the clear sequence runs.
REQ-015 valid_count  out  SEL_W+1  shall be the number of valid entries.
REQ-016 all_valid  out  1  shall be high when valid_count == DEPTH.
REQ-017 wr_err  out  1  shall pulse one cycle for each rejected write.

Function
REQ-018 Each entry shall hold DATA_W data bits plus one valid bit.
REQ-019 An accepted write shall update data, set valid, on the next edge.
REQ-020 A write shall be rejected (no state change, wr_err=1 next cycle) if in_sel >= DEPTH or clear_busy=1.
REQ-021 valid_count shall increment only when an accepted write targets an invalid entry.
REQ-022 Reads shall be combinational; write-first bypass: if an accepted write targets rd_sel_x this cycle, rd_data_x shall show the value being written and rd_valid_x=1.
REQ-023 rd_sel_x >= DEPTH shall return rd_data_x=0, rd_valid_x=0.
REQ-024 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on clear_start; clear index starts at 0.
REQ-025 In CLEAR one entry per cycle (index 0..DEPTH-1) shall be zeroed and invalidated; valid_count decrements if that entry was valid.
REQ-026 CLEAR->IDLE after index DEPTH-1 is cleared; total clear_busy duration exactly DEPTH cycles.
REQ-027 clear_start while in CLEAR shall be ignored (no restart).
REQ-028 clear_start and w_enable in the same IDLE cycle: clear wins, write rejected with wr_err.
REQ-029 Bypass shall not apply to rejected writes.

Reset
REQ-030 On n_rst low: all data 0, all valid 0, FSM IDLE, clear index 0, valid_count 0, all_valid 0, clear_busy 0, wr_err 0, regardless of in-progress clear.

Configuration
REQ-031 Macro RESULT_BANK_ACCUM_EN defined: accepted write with accum=1 shall store (old data + in_data) modulo 2^DATA_W, where old data is 0 if the entry is invalid; bypass shows the sum.
REQ-032 Macro RESULT_BANK_ACCUM_EN undefined: accum shall be ignored; all writes overwrite; no adder synthesised.

Structure
REQ-033 Shared package result_pkg shall hold the clear-FSM state enum and default DATA_W/DEPTH constants.
REQ-034 Sub-module result_clear_seq shall implement the clear FSM and index counter; storage and read muxing stay in result_bank.

Verification
REQ-035 Reset, write 0xDEADBEEF to entry 3 -> next cycle rd_sel_a=3 gives 0xDEADBEEF, rd_valid_a=1, valid_count=1.
REQ-036 Write 0x55 to entry 5 with rd_sel_b=5 same cycle -> rd_data_b=0x55, rd_valid_b=1 that cycle (bypass).
REQ-037 Fill all 16 entries -> all_valid=1; clear_start -> clear_busy high 16 cycles, valid_count steps 16->0, write during clear gives wr_err pulse and no change.
REQ-038 DEPTH=10, write to in_sel=12 -> wr_err=1, valid_count unchanged; read index 12 -> data 0, valid 0.
REQ-039 ACCUM_EN: write 0xFFFFFFFF then accum-write 2 to entry 1 -> entry 1 = 0x00000001; without macro same stimulus -> 0x00000002.
REQ-040 Assert n_rst mid-clear at index 7 -> all outputs at reset values, FSM IDLE, entries 8..15 read 0 invalid.
